coeff_lut_loader: RTL and testbench

COEFF_LUT_LOADER -- requirements
Module: coeff_lut_loader

---
 rtl/coeff_lut_loader_pkg.sv | 14 +
 rtl/coeff_lut_loader_da_subset_sum.sv | 22 ++
 rtl/coeff_lut_loader.sv | 138 +++++++++++++
 tb/tb_coeff_lut_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_lut_loader_pkg.sv
// rtl/coeff_lut_loader_pkg.sv - shared filter package: FSM encodings and tap/width defaults
package coeff_lut_loader_pkg;

    localparam int NTAPS_DEF = 4;
    localparam int CW_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_BUILD   = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

endpackage

// File: rtl/coeff_lut_loader_da_subset_sum.sv
// rtl/coeff_lut_loader_da_subset_sum.sv - combinational DA subset sum of coefficients selected by address bits
module da_subset_sum #(
    parameter int NTAPS = 4,
    parameter int CW    = 16,
    parameter int LW    = CW + $clog2(NTAPS)
) (
    input  logic [NTAPS*CW-1:0] i_coeffs,
    input  logic [NTAPS-1:0]    i_addr,
    output logic [LW-1:0]       o_sum
);

    // Sign-extend each selected tap to the LUT width and accumulate
    always_comb begin
        o_sum = '0;
        for (int j = 0; j < NTAPS; j++) begin
            if (i_addr[j]) begin
                o_sum = o_sum + LW'($signed(i_coeffs[j*CW +: CW]));
            end
        end
    end

endmodule

// File: rtl/coeff_lut_loader.sv
// rtl/coeff_lut_loader.sv - collects NTAPS coefficients and writes the 2^NTAPS-entry DA LUT
module coeff_lut_loader
    import coeff_lut_loader_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int CW    = CW_DEF,
    parameter int LW    = CW + $clog2(NTAPS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_start,
    input  logic             coeff_valid,
    input  logic [CW-1:0]    coeff_data,
    output logic             coeff_ready,
    output logic             lut_we,
    output logic [NTAPS-1:0] lut_addr,
    output logic [LW-1:0]    lut_wdata,
    output logic             busy,
    output logic             CLOAD
);

    localparam int CNTW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNTW-1:0]     r_cnt;
    logic [NTAPS-1:0]    r_addr;
    logic [CW-1:0]       r_coeff [NTAPS];
    logic [NTAPS*CW-1:0] w_coeff_vec;
    logic [LW-1:0]       w_sum;
    logic                w_accept;
    logic                w_last_tap;
    logic                w_last_addr;

    // Accept is only possible in COLLECT, where coeff_ready is high by construction
    assign w_accept    = (r_state == ST_COLLECT) && coeff_valid;
    assign w_last_tap  = (r_cnt == CNTW'(NTAPS - 1));
    assign w_last_addr = (r_addr == {NTAPS{1'b1}});

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; load_start only matters in IDLE and DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (load_start) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_accept && w_last_tap) w_state_nxt = ST_BUILD;
            ST_BUILD:   if (w_last_addr) w_state_nxt = ST_DONE;
            ST_DONE:    if (load_start) w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Tap counter, coefficient store and LUT address sweep
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_addr <= '0;
            for (int j = 0; j < NTAPS; j++) begin
                r_coeff[j] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (load_start) r_cnt <= '0;
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_coeff[r_cnt] <= coeff_data;
                        r_cnt          <= r_cnt + CNTW'(1);
                        if (w_last_tap) r_addr <= '0;
                    end
                end
                ST_BUILD: begin
                    // Wraps back to zero after the last entry
                    r_addr <= r_addr + NTAPS'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Flatten the coefficient registers for the subset-sum adder
    always_comb begin
        w_coeff_vec = '0;
        for (int j = 0; j < NTAPS; j++) begin
            w_coeff_vec[j*CW +: CW] = r_coeff[j];
        end
    end

    da_subset_sum #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .LW    (LW)
    ) u_subset_sum (
        .i_coeffs (w_coeff_vec),
        .i_addr   (r_addr),
        .o_sum    (w_sum)
    );

    // Moore outputs decoded from registered state; write bus is held at zero outside BUILD
    always_comb begin
        coeff_ready = 1'b0;
        lut_we      = 1'b0;
        lut_addr    = '0;
        lut_wdata   = '0;
        busy        = 1'b0;
        CLOAD       = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                coeff_ready = 1'b1;
                busy        = 1'b1;
            end
            ST_BUILD: begin
                lut_we    = 1'b1;
                lut_addr  = r_addr;
                lut_wdata = w_sum;
                busy      = 1'b1;
            end
            ST_DONE: begin
                CLOAD = 1'b1;
            end
            default: begin
                coeff_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_coeff_lut_loader.sv
// tb/tb_coeff_lut_loader.sv - directed self-checking bench for coeff_lut_loader
module tb_coeff_lut_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load_start;
    logic        coeff_valid;
    logic [15:0] coeff_data;
    logic        coeff_ready;
    logic        lut_we;
    logic [3:0]  lut_addr;
    logic [17:0] lut_wdata;
    logic        busy;
    logic        CLOAD;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] lut_mem [16];
    int          wr_cnt = 0;
    int          order_err = 0;
    int          idle_err = 0;
    logic [3:0]  exp_addr = 4'd0;

    always #5 clk = ~clk;

    coeff_lut_loader dut (
        .clk         (clk),
        .resetn      (resetn),
        .load_start  (load_start),
        .coeff_valid (coeff_valid),
        .coeff_data  (coeff_data),
        .coeff_ready (coeff_ready),
        .lut_we      (lut_we),
        .lut_addr    (lut_addr),
        .lut_wdata   (lut_wdata),
        .busy        (busy),
        .CLOAD       (CLOAD)
    );

    // LUT write capture, sampled on the falling edge
    always @(negedge clk) begin
        if (lut_we === 1'b1) begin
            if (lut_addr !== exp_addr) order_err++;
            lut_mem[lut_addr] = lut_wdata;
            wr_cnt++;
            exp_addr = exp_addr + 4'd1;
        end else if (lut_addr !== 4'd0 || lut_wdata !== 18'd0) begin
            idle_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        wr_cnt    = 0;
        exp_addr  = 4'd0;
        order_err = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_set(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3,
                            output int accepted);
        logic [15:0] v [4];
        logic        rdy;
        int          guard;
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            coeff_valid = 1'b1;
            coeff_data  = v[k];
            guard = 0;
            rdy   = 1'b0;
            while (!rdy && guard < 20) begin
                rdy = coeff_ready;
                tick();
                guard++;
            end
            if (rdy) accepted++;
        end
        coeff_valid = 1'b0;
        coeff_data  = 16'h0;
    endtask

    task automatic run_build(output int cyc);
        cyc = 0;
        while (CLOAD !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; load_start = 1'b0; coeff_valid = 1'b0; coeff_data = 16'h0;
        repeat (3) tick();
        n_cmp++; if ({coeff_ready, lut_we, lut_addr, lut_wdata, busy, CLOAD} !== 26'd0) begin n_err++; $display("FAIL reset_outputs got=%h want=0", {coeff_ready, lut_we, lut_addr, lut_wdata, busy, CLOAD}); end
        resetn = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({coeff_ready, lut_we, busy, CLOAD} !== 4'd0) begin n_err++; $display("FAIL idle_after_release got=%b want=0000", {coeff_ready, lut_we, busy, CLOAD}); end
    endtask

    task automatic test_basic();
        int acc, cyc;
        start_load();
        n_cmp++; if ({coeff_ready, busy, CLOAD} !== 3'b110) begin n_err++; $display("FAIL basic_collect got=%b want=110", {coeff_ready, busy, CLOAD}); end
        send_set(16'd1, 16'd2, 16'd3, 16'd4, acc);
        n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL basic_accepted got=%0d want=4", acc); end
        n_cmp++; if ({lut_we, lut_addr, coeff_ready, busy} !== 7'b1_0000_0_1) begin n_err++; $display("FAIL basic_build_entry got=%b want=1000001", {lut_we, lut_addr, coeff_ready, busy}); end
        run_build(cyc);
        n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL basic_cload_latency got=%0d want=16", cyc); end
        n_cmp++; if (wr_cnt !== 16 || order_err !== 0) begin n_err++; $display("FAIL basic_write_seq writes=%0d order_err=%0d want=16/0", wr_cnt, order_err); end
        n_cmp++; if ({lut_we, busy} !== 2'b00) begin n_err++; $display("FAIL basic_done_outputs got=%b want=00", {lut_we, busy}); end
        n_cmp++; if (lut_mem[0] !== 18'd0) begin n_err++; $display("FAIL basic_lut0 got=%h want=0", lut_mem[0]); end
        n_cmp++; if (lut_mem[1] !== 18'd1) begin n_err++; $display("FAIL basic_lut1 got=%h want=1", lut_mem[1]); end
        n_cmp++; if (lut_mem[3] !== 18'd3) begin n_err++; $display("FAIL basic_lut3 got=%h want=3", lut_mem[3]); end
        n_cmp++; if (lut_mem[5] !== 18'd4) begin n_err++; $display("FAIL basic_lut5 got=%h want=4", lut_mem[5]); end
        n_cmp++; if (lut_mem[10] !== 18'd6) begin n_err++; $display("FAIL basic_lut10 got=%h want=6", lut_mem[10]); end
        n_cmp++; if (lut_mem[15] !== 18'd10) begin n_err++; $display("FAIL basic_lut15 got=%h want=a", lut_mem[15]); end
        repeat (3) tick();
        n_cmp++; if (CLOAD !== 1'b1) begin n_err++; $display("FAIL basic_cload_held got=%b want=1", CLOAD); end
    endtask

    task automatic test_signed();
        int acc, cyc;
        start_load();
        n_cmp++; if (CLOAD !== 1'b0) begin n_err++; $display("FAIL signed_cload_fall got=%b want=0", CLOAD); end
        send_set(16'hFFFF, 16'h0001, 16'h7FFF, 16'h7FFF, acc);
        run_build(cyc);
        n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL signed_latency got=%0d want=16", cyc); end
        n_cmp++; if (lut_mem[1] !== 18'h3FFFF) begin n_err++; $display("FAIL signed_lut1 got=%h want=3ffff", lut_mem[1]); end
        n_cmp++; if (lut_mem[3] !== 18'h00000) begin n_err++; $display("FAIL signed_lut3 got=%h want=0", lut_mem[3]); end
        n_cmp++; if (lut_mem[12] !== 18'h0FFFE) begin n_err++; $display("FAIL signed_lut12 got=%h want=0fffe", lut_mem[12]); end
        n_cmp++; if (lut_mem[15] !== 18'h0FFFE) begin n_err++; $display("FAIL signed_lut15 got=%h want=0fffe", lut_mem[15]); end
        n_cmp++; if (lut_mem[5] !== 18'h07FFE) begin n_err++; $display("FAIL signed_lut5 got=%h want=07ffe", lut_mem[5]); end
    endtask

    task automatic test_backpressure();
        bit          vpat [7];
        logic [15:0] vals [4];
        int          k, cyc;
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vals = '{16'd1, 16'd2, 16'd3, 16'd4};
        k = 0;
        start_load();
        for (int i = 0; i < 7; i++) begin
            coeff_valid = vpat[i];
            coeff_data  = vpat[i] ? vals[k] : 16'hDEAD;
            if (vpat[i]) k++;
            if (i == 6) begin
                n_cmp++; if ({coeff_ready, lut_we} !== 2'b10) begin n_err++; $display("FAIL bp_still_collecting got=%b want=10", {coeff_ready, lut_we}); end
            end
            tick();
        end
        coeff_valid = 1'b0;
        coeff_data  = 16'h0;
        n_cmp++; if ({lut_we, lut_addr, coeff_ready} !== 6'b1_0000_0) begin n_err++; $display("FAIL bp_build_entry got=%b want=100000", {lut_we, lut_addr, coeff_ready}); end
        run_build(cyc);
        n_cmp++; if (wr_cnt !== 16 || order_err !== 0) begin n_err++; $display("FAIL bp_write_seq writes=%0d order_err=%0d want=16/0", wr_cnt, order_err); end
        n_cmp++; if ({lut_mem[1], lut_mem[3], lut_mem[5], lut_mem[15]} !== {18'd1, 18'd3, 18'd4, 18'd10}) begin n_err++; $display("FAIL bp_lut got=%h/%h/%h/%h want=1/3/4/a", lut_mem[1], lut_mem[3], lut_mem[5], lut_mem[15]); end
        n_cmp++; if (lut_mem[2] !== 18'd2) begin n_err++; $display("FAIL bp_lut2 got=%h want=2", lut_mem[2]); end
    endtask

    task automatic test_mid_build_reset();
        int acc, cyc, guard;
        start_load();
        send_set(16'd1, 16'd2, 16'd3, 16'd4, acc);
        guard = 0;
        while (lut_addr !== 4'd7 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++; if (lut_addr !== 4'd7) begin n_err++; $display("FAIL mid_reach_addr7 got=%0d want=7", lut_addr); end
        resetn = 1'b0;
        #1;
        n_cmp++; if ({lut_we, CLOAD, busy, coeff_ready, lut_addr, lut_wdata} !== 26'd0) begin n_err++; $display("FAIL mid_async_reset got=%h want=0", {lut_we, CLOAD, busy, coeff_ready, lut_addr, lut_wdata}); end
        repeat (2) tick();
        resetn = 1'b1;
        wr_cnt = 0;
        repeat (5) tick();
        n_cmp++; if (wr_cnt !== 0 || {busy, CLOAD} !== 2'b00) begin n_err++; $display("FAIL mid_stays_idle writes=%0d busy_cload=%b want=0/00", wr_cnt, {busy, CLOAD}); end
        for (int i = 0; i < 16; i++) lut_mem[i] = 18'h2AAAA;
        start_load();
        send_set(16'd1, 16'd2, 16'd4, 16'd8, acc);
        run_build(cyc);
        n_cmp++; if (cyc !== 16 || wr_cnt !== 16) begin n_err++; $display("FAIL mid_reload_build cycles=%0d writes=%0d want=16/16", cyc, wr_cnt); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (lut_mem[i] !== 18'(i)) begin n_err++; $display("FAIL mid_reload_lut[%0d] got=%h want=%h", i, lut_mem[i], 18'(i)); end
        end
    endtask

    task automatic test_reload_ignore();
        int cyc;
        start_load();
        n_cmp++; if ({CLOAD, busy} !== 2'b01) begin n_err++; $display("FAIL ign_cload_fall got=%b want=01", {CLOAD, busy}); end
        coeff_valid = 1'b1; coeff_data = 16'd5;
        tick();
        coeff_valid = 1'b0; coeff_data = 16'h0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        coeff_valid = 1'b1; coeff_data = 16'd0;
        repeat (3) tick();
        coeff_valid = 1'b0;
        n_cmp++; if ({lut_we, lut_addr} !== 5'b1_0000) begin n_err++; $display("FAIL ign_collect_pulse got=%b want=10000", {lut_we, lut_addr}); end
        repeat (3) tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        run_build(cyc);
        n_cmp++; if (wr_cnt !== 16 || order_err !== 0 || CLOAD !== 1'b1) begin n_err++; $display("FAIL ign_build_pulse writes=%0d order_err=%0d cload=%b want=16/0/1", wr_cnt, order_err, CLOAD); end
        n_cmp++; if (lut_mem[1] !== 18'd5) begin n_err++; $display("FAIL ign_lut1 got=%h want=5", lut_mem[1]); end
        n_cmp++; if (lut_mem[15] !== 18'd5) begin n_err++; $display("FAIL ign_lut15 got=%h want=5", lut_mem[15]); end
        n_cmp++; if (lut_mem[14] !== 18'd0) begin n_err++; $display("FAIL ign_lut14 got=%h want=0", lut_mem[14]); end
        n_cmp++; if (idle_err !== 0) begin n_err++; $display("FAIL idle_bus_nonzero got=%0d want=0", idle_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_mid_build_reset();
        test_reload_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
